// File: rtl/alu_seq_ctrl.sv
// Purpose : instruction sequencer that fetches from a synchronous program ROM and dispatches ALU ops to alu_mod.
// Latency : ALU op = FETCH + DECODE + >=1 EXEC cycle (3 min); NOP/JMP/JZ = 2 cycles; HALT parks the sequencer.
// Backpr. : EXEC holds alu_en and all decoded fields until alu_ready; nothing upstream can stall the ROM read.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-low reset
//   start             - (re)start at address 0, honoured only in IDLE or HALTED
//   instr_data        - ROM read data, valid one cycle after instr_addr
//   alu_out/alu_ready - ALU result and completion handshake (looked at only in EXEC)
//   instr_addr        - program counter to the ROM
//   op_code, *_choice - decoded fields of the last ALU instruction
//   push, pop         - one-cycle pulses in the first EXEC cycle
//   alu_en            - high for the whole of EXEC
//   busy, halted      - status: FETCH/DECODE/EXEC, and HALTED
//   zero_flag         - last completed ALU result was zero
module alu_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int IWIDTH  = 8,
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_ready,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic [IWIDTH-1:0]  op_code,
    output logic [1:0]         source1_choice,
    output logic [1:0]         source2_choice,
    output logic [1:0]         dest_choice,
    output logic               push,
    output logic               pop,
    output logic               alu_en,
    output logic               busy,
    output logic               halted,
    output logic               zero_flag
);

    // Reserved opcodes sit at the top of the opcode space (all ones and just below).
    localparam logic [IWIDTH-1:0] OP_NOP  = '0;
    localparam logic [IWIDTH-1:0] OP_HALT = {IWIDTH{1'b1}};
    localparam logic [IWIDTH-1:0] OP_JMP  = {{(IWIDTH-2){1'b1}}, 2'b10};
    localparam logic [IWIDTH-1:0] OP_JZ   = {{(IWIDTH-2){1'b1}}, 2'b01};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [1:0]        ir_pp, ir_pp_nxt;          // {push, pop} bits of the instruction in flight
    logic              first_exec, first_exec_nxt;
    logic              zero_q, zero_nxt;
    logic [IWIDTH-1:0] op_q, op_nxt;
    logic [1:0]        src1_q, src1_nxt;
    logic [1:0]        src2_q, src2_nxt;
    logic [1:0]        dest_q, dest_nxt;

    // Decode straight off the ROM data bus; it is only meaningful in DECODE.
    logic [IWIDTH-1:0] dec_op;
    logic [ADDR_W-1:0] dec_target;
    logic [ADDR_W-1:0] pc_inc;
    logic              unused_operand_hi;

    assign dec_op            = instr_data[IWIDTH+15:16];
    assign dec_target        = instr_data[ADDR_W-1:0];
    assign pc_inc            = pc + ADDR_W'(1);   // wraps modulo 2^ADDR_W
    // Operand bits above the jump target carry no meaning for this sequencer.
    assign unused_operand_hi = ^instr_data[7:ADDR_W];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ir_pp_nxt      = ir_pp;
        first_exec_nxt = 1'b0;
        zero_nxt       = zero_q;
        op_nxt         = op_q;
        src1_nxt       = src1_q;
        src2_nxt       = src2_q;
        dest_nxt       = dest_q;

        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_nxt    = '0;
                    state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                state_nxt = S_DECODE;
            end

            S_DECODE: begin
                ir_pp_nxt = instr_data[9:8];
                if (dec_op == OP_HALT) begin
                    state_nxt = S_HALTED;
                end else if (dec_op == OP_JMP) begin
                    pc_nxt    = dec_target;
                    state_nxt = S_FETCH;
                end else if (dec_op == OP_JZ) begin
                    pc_nxt    = zero_q ? dec_target : pc_inc;
                    state_nxt = S_FETCH;
                end else if (dec_op == OP_NOP) begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end else begin
                    // ALU op: capture the fields so they stay put for the whole handshake
                    // and keep their value once it completes.
                    op_nxt         = dec_op;
                    src1_nxt       = instr_data[15:14];
                    src2_nxt       = instr_data[13:12];
                    dest_nxt       = instr_data[11:10];
                    first_exec_nxt = 1'b1;
                    state_nxt      = S_EXEC;
                end
            end

            S_EXEC: begin
                if (alu_ready) begin
                    zero_nxt  = (alu_out == '0);
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= '0;
            ir_pp      <= '0;
            first_exec <= 1'b0;
            zero_q     <= 1'b0;
            op_q       <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            dest_q     <= '0;
        end else begin
            pc         <= pc_nxt;
            ir_pp      <= ir_pp_nxt;
            first_exec <= first_exec_nxt;
            zero_q     <= zero_nxt;
            op_q       <= op_nxt;
            src1_q     <= src1_nxt;
            src2_q     <= src2_nxt;
            dest_q     <= dest_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes decode from the state register so an asynchronous
    // reset mid-EXEC removes them without waiting for a clock.
    // ------------------------------------------------------------------
    assign instr_addr     = pc;
    assign op_code        = op_q;
    assign source1_choice = src1_q;
    assign source2_choice = src2_q;
    assign dest_choice    = dest_q;
    assign zero_flag      = zero_q;

    assign alu_en = (state == S_EXEC);
    assign push   = (state == S_EXEC) && first_exec && ir_pp[1];
    assign pop    = (state == S_EXEC) && first_exec && ir_pp[0];
    assign busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    assign halted = (state == S_HALTED);

endmodule
